// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the arbiter FSM state encoding, the read-owner encoding, the
// request bundle both ports present to the arbiter, and a word-alignment
// helper for memory addresses.
package dmem_pkg;

  // Byte-address width of the data memory this slice is built for.
  localparam int unsigned DMEM_ADDR_W = 10;

  // Byte enables driven on every read.
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // One access as seen by the memory: write flag, byte address, data, enables.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            wdata;
    logic [3:0]             be;
  } mem_req_t;

  // Clears the two byte-offset bits so the memory only ever sees word addresses.
  function automatic logic [DMEM_ADDR_W-1:0] word_align(input logic [DMEM_ADDR_W-1:0] addr);
    return addr & ~(DMEM_ADDR_W'(3));
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating wait counter for the DMA starvation guard.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         a contended DMA cycle was denied
//   clr         DMA was granted or stopped requesting (takes priority over inc)
//   at_max      counter has reached MAX_WAIT; DMA wins the next contended cycle
module dmem_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Count denied cycles, hold at MAX_WAIT, clear on grant or request drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(MAX_WAIT))) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign at_max = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM
// stage (port C) and the DMA/debug loader (port D). At most one access is
// issued per cycle; the grant is combinational so m_* carry the winner's
// fields in the same cycle. Read data returns one cycle later on the port
// that issued the read. DMA may lock the memory for multi-beat bursts.
//
// Ports:
//   c_*  MEM-stage request in, stall / load-return out
//   d_*  DMA request (with burst lock) in, grant / read-return out
//   m_*  data-memory interface (1-cycle synchronous read latency)
//
// Build option: define DMEM_ARB_STARVE_GUARD_EN to let DMA win a contended
// cycle after MAX_WAIT consecutive denied cycles. Without it, C has strict
// priority whenever the arbiter is not locked.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_req_i,
  input  logic                  c_we_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [31:0]           c_wdata_i,
  input  logic [3:0]            c_be_i,
  output logic                  c_stall_o,
  output logic                  c_rvalid_o,
  output logic [31:0]           c_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic                  d_lock_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  input  logic [3:0]            d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic                  m_re_o,
  output logic                  m_we_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [31:0]           m_wdata_o,
  output logic [3:0]            m_be_o,
  input  logic [31:0]           m_rdata_i
);

  // The request bundle is sized by the package; reject mismatched builds.
  if ((ADDR_WIDTH != DMEM_ADDR_W) || (MAX_WAIT == 32'd0)) begin : g_param_check
    $error("dmem_arbiter: ADDR_WIDTH must match DMEM_ADDR_W and MAX_WAIT must be nonzero");
  end

  arb_state_t  state, state_next;
  logic        c_gnt, d_gnt, force_d;
  mem_req_t    c_fields, d_fields, sel;
  logic        rd_pend;
  owner_t      rd_owner;
  logic [31:0] c_rdata_hold, d_rdata_hold;

  assign c_fields = '{we: c_we_i, addr: c_addr_i, wdata: c_wdata_i, be: c_be_i};
  assign d_fields = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_be_i};

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic starve_inc, starve_clr;

  // Only denials while unlocked count; a locked burst never denies a live D request.
  assign starve_inc = (state == ARB_IDLE) && d_req_i && !d_gnt;
  assign starve_clr = d_gnt || !d_req_i;

  dmem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (force_d)
  );
`else
  assign force_d = 1'b0;
`endif

  // Grant decision and next FSM state.
  always_comb begin
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (c_req_i && !(d_req_i && force_d)) begin
          c_gnt = 1'b1;
        end else begin
          c_gnt = 1'b0;
        end
        d_gnt = d_req_i && !c_gnt;
        if (d_gnt && d_lock_i) begin
          state_next = ARB_LOCKED;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        d_gnt = d_req_i;
        // A dropped request aborts the burst just like a final (unlocked) beat.
        if (!d_req_i || !d_lock_i) begin
          state_next = ARB_IDLE;
        end else begin
          state_next = ARB_LOCKED;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Memory-side mux: winner's fields, or all zeros when nothing is granted.
  always_comb begin
    sel    = '0;
    m_re_o = 1'b0;
    m_we_o = 1'b0;
    m_be_o = 4'h0;
    if (c_gnt) begin
      sel = c_fields;
    end else if (d_gnt) begin
      sel = d_fields;
    end else begin
      sel = '0;
    end
    m_we_o = (c_gnt || d_gnt) && sel.we;
    m_re_o = (c_gnt || d_gnt) && !sel.we;
    if (m_re_o) begin
      m_be_o = BE_ALL;
    end else begin
      m_be_o = sel.be;
    end
  end

  assign m_addr_o  = word_align(sel.addr);
  assign m_wdata_o = sel.wdata;
  assign c_stall_o = c_req_i && !c_gnt;
  assign d_gnt_o   = d_gnt;

  // FSM state, in-flight read tag and per-port held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      rd_pend      <= 1'b0;
      rd_owner     <= OWN_C;
      c_rdata_hold <= 32'h0;
      d_rdata_hold <= 32'h0;
    end else begin
      state   <= state_next;
      rd_pend <= m_re_o;
      if (d_gnt) begin
        rd_owner <= OWN_D;
      end else begin
        rd_owner <= OWN_C;
      end
      if (c_rvalid_o) begin
        c_rdata_hold <= m_rdata_i;
      end else begin
        c_rdata_hold <= c_rdata_hold;
      end
      if (d_rvalid_o) begin
        d_rdata_hold <= m_rdata_i;
      end else begin
        d_rdata_hold <= d_rdata_hold;
      end
    end
  end

  // The returning word passes straight through in its cycle; afterwards the hold register keeps it.
  assign c_rvalid_o = rd_pend && (rd_owner == OWN_C);
  assign d_rvalid_o = rd_pend && (rd_owner == OWN_D);
  assign c_rdata_o  = c_rvalid_o ? m_rdata_i : c_rdata_hold;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : d_rdata_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a small word memory model sits on
// the m_* port, expected read returns are queued when a read is expected to
// issue and are compared when rvalid appears.
module tb_dmem_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [31:0]   c_wdata, d_wdata;
  logic [3:0]    c_be, d_be;
  logic          c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0]   c_rdata, d_rdata;
  logic          m_re, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_be;

  int n_checks  = 0;
  int n_errors  = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic        port_d;
    logic [31:0] data;
    int          due;
  } sb_entry_t;

  sb_entry_t   sb[$];
  sb_entry_t   mon_e;
  logic [31:0] mem [0:255];

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_req_i    (c_req),
    .c_we_i     (c_we),
    .c_addr_i   (c_addr),
    .c_wdata_i  (c_wdata),
    .c_be_i     (c_be),
    .c_stall_o  (c_stall),
    .c_rvalid_o (c_rvalid),
    .c_rdata_o  (c_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_lock_i   (d_lock),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_be_i     (d_be),
    .d_gnt_o    (d_gnt),
    .d_rvalid_o (d_rvalid),
    .d_rdata_o  (d_rdata),
    .m_re_o     (m_re),
    .m_we_o     (m_we),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_be_o     (m_be),
    .m_rdata_i  (m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [31:0] init_word(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Word memory with byte-enabled writes and one-cycle read latency.
  always @(posedge clk) begin
    if (m_we) begin
      for (int b = 0; b < 4; b++) begin
        if (m_be[b]) mem[m_addr[AW-1:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
    if (m_re) m_rdata <= mem[m_addr[AW-1:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycle_cnt);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = 32'h0; c_be = 4'h0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = 32'h0; d_be = 4'h0;
  endtask

  task automatic chk_bus(input string t, input logic stall, input logic dg, input logic re,
                         input logic we, input logic [AW-1:0] addr, input logic [3:0] be);
    #2;
    check_eq({t, ".stall"}, 32'(c_stall), 32'(stall));
    check_eq({t, ".dgnt"},  32'(d_gnt),   32'(dg));
    check_eq({t, ".re"},    32'(m_re),    32'(re));
    check_eq({t, ".we"},    32'(m_we),    32'(we));
    check_eq({t, ".addr"},  32'(m_addr),  32'(addr));
    check_eq({t, ".be"},    32'(m_be),    32'(be));
  endtask

  task automatic push_rd(input logic port_d, input logic [31:0] data);
    sb_entry_t e;
    e.port_d = port_d;
    e.data   = data;
    e.due    = cycle_cnt + 1;
    sb.push_back(e);
  endtask

  // Read-return monitor: every rvalid must match the oldest queued read, in its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (c_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          check_eq("rv_unexpected", 32'({c_rvalid, d_rvalid}), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rv_cycle", 32'(cycle_cnt), 32'(mon_e.due));
          check_eq("rv_port", 32'({c_rvalid, d_rvalid}), mon_e.port_d ? 32'h1 : 32'h2);
          check_eq("rv_data", d_rvalid ? d_rdata : c_rdata, mon_e.data);
        end
      end else if ((sb.size() != 0) && (sb[0].due <= cycle_cnt)) begin
        mon_e = sb.pop_front();
        check_eq("rv_missing", 32'({c_rvalid, d_rvalid}), mon_e.port_d ? 32'h1 : 32'h2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) next_cycle();

    // Reset state.
    chk_bus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0);
    check_eq("reset.wdata",   m_wdata, 32'h0);
    check_eq("reset.crvalid", 32'(c_rvalid), 32'h0);
    check_eq("reset.drvalid", 32'(d_rvalid), 32'h0);
    check_eq("reset.crdata",  c_rdata, 32'h0);
    check_eq("reset.drdata",  d_rdata, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // C load alone.
    next_cycle();
    c_req = 1'b1; c_addr = 10'h010;
    chk_bus("c_load", 1'b0, 1'b0, 1'b1, 1'b0, 10'h010, 4'hF);
    push_rd(1'b0, init_word(4));
    next_cycle();
    clear_inputs();

    // C store and D write contend: C first, D next cycle.
    next_cycle();
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'h040; c_wdata = 32'h1234_ABCD; c_be = 4'b0011;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h044; d_wdata = 32'h55AA_55AA; d_be = 4'hF;
    chk_bus("contend_c", 1'b0, 1'b0, 1'b0, 1'b1, 10'h040, 4'b0011);
    check_eq("contend_c.wdata", m_wdata, 32'h1234_ABCD);
    next_cycle();
    c_req = 1'b0;
    chk_bus("contend_d", 1'b0, 1'b1, 1'b0, 1'b1, 10'h044, 4'hF);
    check_eq("contend_d.wdata", m_wdata, 32'h55AA_55AA);

    // Read back both words, alternating ports, with an unaligned C address.
    next_cycle();
    clear_inputs();
    c_req = 1'b1; c_addr = 10'h042;
    chk_bus("rb_c", 1'b0, 1'b0, 1'b1, 1'b0, 10'h040, 4'hF);
    push_rd(1'b0, 32'hC0DE_ABCD);
    next_cycle();
    clear_inputs();
    d_req = 1'b1; d_addr = 10'h044;
    chk_bus("rb_d", 1'b0, 1'b1, 1'b1, 1'b0, 10'h044, 4'hF);
    push_rd(1'b1, 32'h55AA_55AA);
    next_cycle();
    clear_inputs();

    // Locked 3-beat DMA burst; C arrives after beat 1 and waits it out.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 10'h100; d_wdata = 32'h1; d_be = 4'hF;
    chk_bus("burst1", 1'b0, 1'b1, 1'b0, 1'b1, 10'h100, 4'hF);
    next_cycle();
    c_req = 1'b1; c_addr = 10'h010;
    d_addr = 10'h104; d_wdata = 32'h2;
    chk_bus("burst2", 1'b1, 1'b1, 1'b0, 1'b1, 10'h104, 4'hF);
    next_cycle();
    d_addr = 10'h108; d_wdata = 32'h3; d_lock = 1'b0;
    chk_bus("burst3", 1'b1, 1'b1, 1'b0, 1'b1, 10'h108, 4'hF);
    next_cycle();
    d_req = 1'b0;
    chk_bus("burst_c", 1'b0, 1'b0, 1'b1, 1'b0, 10'h010, 4'hF);
    push_rd(1'b0, init_word(4));
    next_cycle();
    clear_inputs();

    // Locked burst aborted after beat 1: idle cycle, then pending C.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1; d_addr = 10'h200; d_wdata = 32'hA; d_be = 4'hF;
    chk_bus("abort1", 1'b0, 1'b1, 1'b0, 1'b1, 10'h200, 4'hF);
    next_cycle();
    clear_inputs();
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'h080; c_wdata = 32'hB; c_be = 4'hF;
    chk_bus("abort_gap", 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 4'h0);
    next_cycle();
    chk_bus("abort_c", 1'b0, 1'b0, 1'b0, 1'b1, 10'h080, 4'hF);
    next_cycle();
    clear_inputs();

    // Continuous contention: starvation guard behaviour.
    next_cycle();
    c_req = 1'b1; c_we = 1'b1; c_addr = 10'h0C0; c_wdata = 32'hC; c_be = 4'hF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h0C4; d_wdata = 32'hD; d_be = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logic exp_d;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      exp_d = (i == 4);
`else
      exp_d = 1'b0;
`endif
      chk_bus($sformatf("starve%0d", i), exp_d, exp_d, 1'b0, 1'b1,
              exp_d ? 10'h0C4 : 10'h0C0, 4'hF);
      next_cycle();
    end
    c_req = 1'b0;
    chk_bus("starve_release", 1'b0, 1'b1, 1'b0, 1'b1, 10'h0C4, 4'hF);
    next_cycle();
    clear_inputs();

    // D read then C read: in-order returns, D data held afterwards.
    next_cycle();
    d_req = 1'b1; d_addr = 10'h020;
    chk_bus("dread", 1'b0, 1'b1, 1'b1, 1'b0, 10'h020, 4'hF);
    push_rd(1'b1, init_word(8));
    next_cycle();
    clear_inputs();
    c_req = 1'b1; c_addr = 10'h024;
    chk_bus("cread", 1'b0, 1'b0, 1'b1, 1'b0, 10'h024, 4'hF);
    push_rd(1'b0, init_word(9));
    next_cycle();
    clear_inputs();
    #2;
    check_eq("dhold.rvalid", 32'(d_rvalid), 32'h0);
    check_eq("dhold.rdata",  d_rdata, init_word(8));
    next_cycle();

    // D read, reset before its return: response discarded, rdata cleared.
    d_req = 1'b1; d_addr = 10'h020;
    chk_bus("rst_dread", 1'b0, 1'b1, 1'b1, 1'b0, 10'h020, 4'hF);
    next_cycle();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check_eq("rst_mid.drvalid", 32'(d_rvalid), 32'h0);
    check_eq("rst_mid.crvalid", 32'(c_rvalid), 32'h0);
    check_eq("rst_mid.drdata",  d_rdata, 32'h0);
    check_eq("rst_mid.crdata",  c_rdata, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    c_req = 1'b1; c_addr = 10'h024;
    chk_bus("rst_cread", 1'b0, 1'b0, 1'b1, 1'b0, 10'h024, 4'hF);
    push_rd(1'b0, init_word(9));
    next_cycle();
    clear_inputs();

    repeat (3) next_cycle();
    check_eq("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
